// File: rtl/wb_regfile_pkg.sv
// Pipeline writeback definitions shared by MEM/WB, control, forwarding and the register file.
package wb_regfile_pkg;

  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned WB_W        = 3;
  localparam int unsigned WB_REGWRITE = 0;
  localparam int unsigned WB_SEL_LSB  = 1;
  localparam int unsigned WB_SEL_MSB  = 2;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_LINK = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  // Bit layout matches WB_i: [2:1] select, [0] RegWrite.
  typedef struct packed {
    wb_sel_e sel;
    logic    regwrite;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_mux.sv
// Writeback data select: ALU result, memory word or link value.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  wb_sel_e           sel,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] mem,
  input  logic [DATA_W-1:0] link,
  output logic [DATA_W-1:0] data_c
);

  // Reserved code falls back to the ALU result.
  always_comb begin
    data_c = alu;
    case (sel)
      SEL_MEM:  data_c = mem;
      SEL_LINK: data_c = link;
      default:  data_c = alu;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file with writeback select, write-through read bypass and commit counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WB_W-1:0]       WB_i,
  input  logic [DATA_W-1:0]     DM_i,
  input  logic [DATA_W-1:0]     alu_ans_i,
  input  logic [ADDR_W-1:0]     WBreg_i,
  input  logic [DATA_W-1:0]     pc_add4_i,
  input  logic [ADDR_W-1:0]     RSaddr_i,
  input  logic [ADDR_W-1:0]     RTaddr_i,
  output logic [DATA_W-1:0]     RSdata_o,
  output logic [DATA_W-1:0]     RTdata_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic                  wb_en_o,
  output logic [31:0]           commit_cnt_o
);

  wb_ctrl_t          ctrl;
  logic [DATA_W-1:0] wb_data;
  logic              wb_en;
  logic [DATA_W-1:0] regs [REG_NUM];
  logic [31:0]       commit_cnt;

  assign ctrl = wb_ctrl_t'(WB_i);

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .sel    (ctrl.sel),
    .alu    (alu_ans_i),
    .mem    (DM_i),
    .link   (pc_add4_i),
    .data_c (wb_data)
  );

  assign wb_en     = ctrl.regwrite && (WBreg_i != ADDR_W'(0));
  assign wb_data_o = wb_data;
  assign wb_en_o   = wb_en;

  // Register array; entry 0 is never written so it stays zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[WBreg_i] <= wb_data;
    end
  end

  // Effective-write counter, wraps silently.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      commit_cnt <= '0;
    end else if (wb_en) begin
      commit_cnt <= commit_cnt + 32'd1;
    end
  end

  assign commit_cnt_o = commit_cnt;

  // Read ports: $0 first, then same-cycle bypass, then the array.
  always_comb begin
    RSdata_o = regs[RSaddr_i];
    if (RSaddr_i == ADDR_W'(0)) begin
      RSdata_o = '0;
    end else if (wb_en && (WBreg_i == RSaddr_i)) begin
      RSdata_o = wb_data;
    end
  end

  always_comb begin
    RTdata_o = regs[RTaddr_i];
    if (RTaddr_i == ADDR_W'(0)) begin
      RTdata_o = '0;
    end else if (wb_en && (WBreg_i == RTaddr_i)) begin
      RTdata_o = wb_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a write scoreboard drained through the read ports.
module tb_wb_regfile;

  logic        clk_i;
  logic        rst_i;
  logic [2:0]  WB_i;
  logic [31:0] DM_i;
  logic [31:0] alu_ans_i;
  logic [4:0]  WBreg_i;
  logic [31:0] pc_add4_i;
  logic [4:0]  RSaddr_i;
  logic [4:0]  RTaddr_i;
  logic [31:0] RSdata_o;
  logic [31:0] RTdata_o;
  logic [31:0] wb_data_o;
  logic        wb_en_o;
  logic [31:0] commit_cnt_o;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  wb_regfile dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .WB_i         (WB_i),
    .DM_i         (DM_i),
    .alu_ans_i    (alu_ans_i),
    .WBreg_i      (WBreg_i),
    .pc_add4_i    (pc_add4_i),
    .RSaddr_i     (RSaddr_i),
    .RTaddr_i     (RTaddr_i),
    .RSdata_o     (RSdata_o),
    .RTdata_o     (RTdata_o),
    .wb_data_o    (wb_data_o),
    .wb_en_o      (wb_en_o),
    .commit_cnt_o (commit_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
    end
  endtask

  // Drive a writeback at the negedge; record what the array must hold afterwards.
  task automatic drive_wb(input logic [2:0] wb, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] dm,
                          input logic [31:0] pc, input logic [31:0] exp_data);
    @(negedge clk_i);
    WB_i      = wb;
    WBreg_i   = rd;
    alu_ans_i = alu;
    DM_i      = dm;
    pc_add4_i = pc;
    if (wb[0] && rd != 5'd0) begin
      exp_t e;
      e.addr = rd;
      e.data = exp_data;
      exp_q.push_back(e);
    end
  endtask

  // After the edge, idle the write port and compare each recorded write through port A.
  task automatic drain(input string tag);
    @(posedge clk_i);
    #1;
    WB_i = 3'b000;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      RSaddr_i = e.addr;
      #1;
      check(tag, RSdata_o, e.data);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_i     = 1'b0;
    WB_i      = 3'b000;
    DM_i      = '0;
    alu_ans_i = '0;
    WBreg_i   = '0;
    pc_add4_i = '0;
    RSaddr_i  = 5'd5;
    RTaddr_i  = 5'd31;
    #12;
    check("reset_rs", RSdata_o, 32'h0);
    check("reset_cnt", commit_cnt_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    drive_wb(3'b001, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h1234);
    #1;
    check("alu_wbdata", wb_data_o, 32'h1234);
    check("alu_wben", 32'(wb_en_o), 32'h1);
    drain("alu_write");
    drive_wb(3'b011, 5'd6, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
    drain("mem_write");
    drive_wb(3'b101, 5'd31, 32'h0, 32'h0, 32'h40, 32'h40);
    drain("link_write");
    check("cnt_after3", commit_cnt_o, 32'd3);

    drive_wb(3'b001, 5'd0, 32'hFFFF, 32'h0, 32'h0, 32'h0);
    RSaddr_i = 5'd0;
    #1;
    check("r0_wben", 32'(wb_en_o), 32'h0);
    check("r0_read", RSdata_o, 32'h0);
    drain("r0_write");
    RSaddr_i = 5'd0;
    #1;
    check("r0_after", RSdata_o, 32'h0);
    check("r0_cnt", commit_cnt_o, 32'd3);

    drive_wb(3'b001, 5'd7, 32'hA5A5, 32'h0, 32'h0, 32'hA5A5);
    RSaddr_i = 5'd7;
    RTaddr_i = 5'd7;
    #1;
    check("bypass_rs", RSdata_o, 32'hA5A5);
    check("bypass_rt", RTdata_o, 32'hA5A5);
    drain("bypass_array");
    RTaddr_i = 5'd7;
    #1;
    check("bypass_rt_after", RTdata_o, 32'hA5A5);

    drive_wb(3'b010, 5'd8, 32'h1111, 32'h55, 32'h0, 32'h0);
    RSaddr_i = 5'd8;
    #1;
    check("nowr_wbdata", wb_data_o, 32'h55);
    check("nowr_wben", 32'(wb_en_o), 32'h0);
    check("nowr_nobypass", RSdata_o, 32'h0);
    drain("nowr");
    RSaddr_i = 5'd8;
    #1;
    check("nowr_reg8", RSdata_o, 32'h0);
    check("nowr_cnt", commit_cnt_o, 32'd4);

    drive_wb(3'b111, 5'd9, 32'h77, 32'h88, 32'h99, 32'h77);
    #1;
    check("rsvd_wbdata", wb_data_o, 32'h77);
    drain("rsvd_write");
    check("cnt_after5", commit_cnt_o, 32'd5);

    @(negedge clk_i);
    force dut.commit_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.commit_cnt;
    #1;
    check("wrap_preload", commit_cnt_o, 32'hFFFF_FFFF);
    WB_i      = 3'b001;
    WBreg_i   = 5'd10;
    alu_ans_i = 32'hC0DE;
    exp_q.push_back('{addr: 5'd10, data: 32'hC0DE});
    drain("wrap_write");
    check("wrap_cnt", commit_cnt_o, 32'h0);

    @(posedge clk_i);
    #2;
    rst_i    = 1'b0;
    RSaddr_i = 5'd5;
    RTaddr_i = 5'd6;
    #1;
    check("midrst_rs", RSdata_o, 32'h0);
    check("midrst_rt", RTdata_o, 32'h0);
    check("midrst_cnt", commit_cnt_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs: it selects writeback data from ALU result, data-memory word or PC+4 (link), and writes the 32×32-bit architectural register file. It provides two combinational read ports to the ID stage with same-cycle write-through bypass. It also keeps a commit counter for CPI measurement.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers (address width 5 fixed)
- DATA_W, 32, register/data width

Ports:
- clk_i  in  1  pipeline clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- WB_i  in  3  writeback control from MEM/WB: bit0 RegWrite, bits[2:1] MemtoReg select
- DM_i  in  32  data-memory read word
- alu_ans_i  in  32  ALU result
- WBreg_i  in  5  destination register number
- pc_add4_i  in  32  PC+4 of the instruction (link value)
- RSaddr_i  in  5  read port A address (ID stage)
- RTaddr_i  in  5  read port B address (ID stage)
- RSdata_o  out  32  read port A data
- RTdata_o  out  32  read port B data
- wb_data_o  out  32  selected writeback value (to EX forwarding mux)
- wb_en_o  out  1  effective write enable (RegWrite and WBreg_i≠0), to forwarding unit
- commit_cnt_o  out  32  count of effective register writes since reset

## Operation
- Select encoding WB_i[2:1]: 00 → alu_ans_i; 01 → DM_i; 10 → pc_add4_i; 11 reserved → alu_ans_i.
- wb_data_o is combinational from the select, regardless of RegWrite.
- wb_en_o = WB_i[0] && (WBreg_i != 0).
- On a rising edge with wb_en_o=1: reg[WBreg_i] ← wb_data_o; commit_cnt_o ← commit_cnt_o + 1.
- Register 0 is hardwired zero: writes are dropped, reads return 0, and the counter does not increment.
- Read ports are combinational. RSdata_o = 0 if RSaddr_i=0; else wb_data_o if wb_en_o and WBreg_i==RSaddr_i (write-through bypass); else reg[RSaddr_i]. RTdata_o is identical with RTaddr_i.
- Both ports may read the same address; both ports get the bypass at the same time.
- commit_cnt_o wraps modulo 2^32 (0xFFFFFFFF → 0) with no flag.

## Timing
- Reset (rst_i low, asynchronous): all registers 0; commit_cnt_o = 0. RSdata_o/RTdata_o therefore read 0. wb_data_o and wb_en_o stay combinational functions of the inputs.
- Reset asserted mid-cycle clears state immediately, with no clock needed. The first write is accepted on the first rising edge after rst_i deasserts.
- Write latency: value is visible in the array one edge after presentation. Through the bypass it is visible in the same cycle (zero latency to ID).
- Read latency: combinational, zero cycles.
- No handshake: one write per cycle maximum, always accepted.

## Structure
- Shared package (pipeline defs): WB field indices (WB_REGWRITE=0, WB_SEL=2:1) and select codes (SEL_ALU=2'b00, SEL_MEM=2'b01, SEL_LINK=2'b10). The MEM/WB register, control unit and forwarding unit use the same constants.
- One sub-module, wb_mux: pure 3-input writeback select, reused by the forwarding path.
- The register array and counter live in the top module.

## Test plan
- Reset: drive rst_i=0 mid-cycle after writes → all reads return 0 and commit_cnt_o=0 immediately, with no clock edge.
- Select: WB_i=3'b001, alu_ans_i=0x1234, WBreg_i=5 → next cycle read $5 gives 0x1234. Then WB_i=3'b011, DM_i=0xDEADBEEF, reg 6 → 0xDEADBEEF. Then WB_i=3'b101, pc_add4_i=0x40, reg 31 → 0x40. commit_cnt_o=3.
- $0: WB_i=3'b001, WBreg_i=0, alu_ans_i=0xFFFF → read $0=0, wb_en_o=0, counter unchanged.
- Bypass: same cycle write reg 7=0xA5A5 with RSaddr_i=RTaddr_i=7 → both outputs 0xA5A5 before the edge; array holds 0xA5A5 after the edge.
- RegWrite low: WB_i=3'b010, WBreg_i=8 → reg 8 unchanged, no bypass, counter unchanged, wb_data_o=DM_i.
- Wrap: force counter to 0xFFFFFFFF, one valid write → commit_cnt_o=0.
